pktc_mem_responder: RTL and testbench
=====================================

Name: pktc_mem_responder

Overview:
- Memory-side responder for the packet-buffer memory interface driven by the DMA FIFO front-ends.
- Holds storage for two FIFO clients (f0, f1), each with its own bank of 2^AWIDTH words.
- Performs an initialisation sweep after reset, then services per-client writes and combinational reads.
- Keeps per-client write statistics and sticky error flags.

Parameters:
DWIDTH, 64, data word width.
AWIDTH, 8, per-client address width; bank depth is 2^AWIDTH.
CNTW, 32, width of the statistics counters.

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
f0_waddr  input  AWIDTH  client 0 write address
f0_wdata  input  DWIDTH  client 0 write data
f0_write  input  1  client 0 write strobe
f0_raddr  input  AWIDTH  client 0 read address
f0_rdata  output  DWIDTH  client 0 read data
f1_waddr, f1_wdata, f1_write, f1_raddr, f1_rdata  same widths and directions as f0, for client 1
init_done  output  1  high once the clear sweep is complete
f0_wr_cnt  output  CNTW  accepted client 0 writes, saturating
f1_wr_cnt  output  CNTW  accepted client 1 writes, saturating
wr_drop  output  1  sticky: a write arrived before init_done
clr_stats  input  1  synchronous clear of the counters and wr_drop

Behaviour:
- Reset is asynchronous and active-high.
- Reset values: state=INIT, sweep pointer=0, init_done=0, f0_wr_cnt=0, f1_wr_cnt=0, wr_drop=0.
- Memory contents are not reset directly; they are cleared by the sweep.
- State machine:
  - INIT: each cycle writes zero to index ptr of both banks, then ptr increments.
  - When ptr reaches 2^AWIDTH-1, that entry is written and the FSM moves to READY.
  - The sweep takes 2^AWIDTH cycles.
  - READY: init_done=1. READY is left only by reset.
- Reset asserted mid-sweep or in READY returns the FSM to INIT and restarts the sweep at ptr 0.
- Writes:
  - In READY, fX_write=1 writes fX_wdata into bank X at fX_waddr on the rising edge.
  - The write is visible on fX_rdata from the next cycle.
  - The two banks are independent, so simultaneous f0 and f1 writes both complete.
- Reads:
  - fX_rdata = bankX[fX_raddr], purely combinational (zero latency). FIFO heads depend on this.
  - fX_rdata is forced to 0 while rst=1 or init_done=0.
  - No write-through bypass: if raddr==waddr while write=1, the old word is returned that cycle.
- Writes while init_done=0:
  - The write is dropped, memory is not modified, and wr_drop is set (sticky).
  - The counters do not increment.
- Counters:
  - fX_wr_cnt increments by 1 per accepted write.
  - Saturates at 2^CNTW-1, with no wrap.
- clr_stats:
  - Zeroes both counters and wr_drop on the next edge.
  - If a write is accepted in the same cycle, clear wins and the counter reads 0.
- Addresses are exactly AWIDTH bits, so no out-of-range access is possible; FIFO pointer wrap maps naturally onto the bank.

Optional Feature:
Macro PKTC_MEM_PARITY_EN.
- When defined:
  - Each bank word stores one extra even-parity bit computed from wdata at write time.
  - The sweep writes parity 0.
  - Outputs f0_par_err and f1_par_err (1 bit each) are added. fX_par_err = recomputed parity of bankX[fX_raddr] XOR stored bit, combinational, gated by init_done.
  - Sticky output par_err_seen is added: it sets on any rising edge where an fX_par_err is high, and clears on reset or clr_stats.
- When not defined: no parity storage and none of these ports exist.

Test Plan:
- Reset, then release -> init_done stays 0 for exactly 256 cycles (AWIDTH=8) and rises on cycle 256; f0_rdata=f1_rdata=0 throughout.
- After init: f0 writes 0xDEADBEEF_00000001 at addr 5, and f1 writes 0x1234 at addr 5 in the same cycle -> next cycle, raddr=5 gives f0_rdata=0xDEADBEEF_00000001 and f1_rdata=0x1234; f0_wr_cnt=1, f1_wr_cnt=1.
- Read/write same address in one cycle: write 0xAA at addr 3, then write 0xBB at addr 3 with raddr=3 -> that cycle f0_rdata=0xAA, next cycle 0xBB.
- Write during INIT (cycle 10 after reset) -> wr_drop=1, f0_wr_cnt=0, and the addressed word reads 0 after init; then clr_stats -> wr_drop=0.
- Counter saturation with CNTW=4: 20 writes -> f0_wr_cnt=15; clr_stats together with a write -> 0.
- Reset asserted at sweep cycle 100 -> init_done=0 immediately, the sweep restarts, and init_done rises 256 cycles after release. With PKTC_MEM_PARITY_EN, forcing a stored parity bit flip -> fX_par_err=1 and par_err_seen=1.

Source files
------------

// File: rtl/pktc_mem_responder.sv
// Memory-side responder for two DMA FIFO clients: zero-clear sweep after reset, per-client banks,
// combinational reads and saturating write statistics. Optional parity: define PKTC_MEM_PARITY_EN.
module pktc_mem_responder #(
    parameter int DWIDTH = 64,
    parameter int AWIDTH = 8,
    parameter int CNTW   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] f0_waddr,
    input  logic [DWIDTH-1:0] f0_wdata,
    input  logic              f0_write,
    input  logic [AWIDTH-1:0] f0_raddr,
    output logic [DWIDTH-1:0] f0_rdata,
    input  logic [AWIDTH-1:0] f1_waddr,
    input  logic [DWIDTH-1:0] f1_wdata,
    input  logic              f1_write,
    input  logic [AWIDTH-1:0] f1_raddr,
    output logic [DWIDTH-1:0] f1_rdata,
    output logic              init_done,
    output logic [CNTW-1:0]   f0_wr_cnt,
    output logic [CNTW-1:0]   f1_wr_cnt,
    output logic              wr_drop,
`ifdef PKTC_MEM_PARITY_EN
    output logic              f0_par_err,
    output logic              f1_par_err,
    output logic              par_err_seen,
`endif
    input  logic              clr_stats
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH-1:0] PTR_ONE  = {{(AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0] PTR_LAST = '1;
    localparam logic [CNTW-1:0]   CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0]   CNT_MAX  = '1;

    typedef enum logic [0:0] {INIT, READY} state_t;

    state_t            state, next_state;
    logic [AWIDTH-1:0] ptr, next_ptr;
    logic              sweep_we;
    logic              acc0, acc1;

    logic [DWIDTH-1:0] bank0 [DEPTH];
    logic [DWIDTH-1:0] bank1 [DEPTH];
`ifdef PKTC_MEM_PARITY_EN
    logic              par0 [DEPTH];
    logic              par1 [DEPTH];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= next_state;
            ptr   <= next_ptr;
        end
    end

    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        sweep_we   = 1'b0;
        case (state)
            INIT: begin
                sweep_we = 1'b1;
                next_ptr = ptr + PTR_ONE;
                if (ptr == PTR_LAST) next_state = READY;
            end
            READY: ;
            default: next_state = INIT;
        endcase
    end

    assign init_done = (state == READY);
    assign acc0 = f0_write && init_done;
    assign acc1 = f1_write && init_done;

    // Storage has no reset; the sweep is what gives it defined contents.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            bank0[ptr] <= '0;
            bank1[ptr] <= '0;
`ifdef PKTC_MEM_PARITY_EN
            par0[ptr]  <= 1'b0;
            par1[ptr]  <= 1'b0;
`endif
        end else begin
            if (acc0) begin
                bank0[f0_waddr] <= f0_wdata;
`ifdef PKTC_MEM_PARITY_EN
                par0[f0_waddr]  <= ^f0_wdata;
`endif
            end
            if (acc1) begin
                bank1[f1_waddr] <= f1_wdata;
`ifdef PKTC_MEM_PARITY_EN
                par1[f1_waddr]  <= ^f1_wdata;
`endif
            end
        end
    end

    assign f0_rdata = (rst || !init_done) ? '0 : bank0[f0_raddr];
    assign f1_rdata = (rst || !init_done) ? '0 : bank1[f1_raddr];

`ifdef PKTC_MEM_PARITY_EN
    assign f0_par_err = init_done && ((^bank0[f0_raddr]) ^ par0[f0_raddr]);
    assign f1_par_err = init_done && ((^bank1[f1_raddr]) ^ par1[f1_raddr]);
`endif

    // Clear takes priority over any increment or drop event in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f0_wr_cnt    <= '0;
            f1_wr_cnt    <= '0;
            wr_drop      <= 1'b0;
`ifdef PKTC_MEM_PARITY_EN
            par_err_seen <= 1'b0;
`endif
        end else if (clr_stats) begin
            f0_wr_cnt    <= '0;
            f1_wr_cnt    <= '0;
            wr_drop      <= 1'b0;
`ifdef PKTC_MEM_PARITY_EN
            par_err_seen <= 1'b0;
`endif
        end else begin
            if (acc0 && (f0_wr_cnt != CNT_MAX)) f0_wr_cnt <= f0_wr_cnt + CNT_ONE;
            if (acc1 && (f1_wr_cnt != CNT_MAX)) f1_wr_cnt <= f1_wr_cnt + CNT_ONE;
            if ((f0_write || f1_write) && !init_done) wr_drop <= 1'b1;
`ifdef PKTC_MEM_PARITY_EN
            if (f0_par_err || f1_par_err) par_err_seen <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_pktc_mem_responder.sv
// Scoreboard bench for pktc_mem_responder: the driver predicts each cycle's outputs from a
// reference model (cycle count since reset, plain arrays) and a negedge monitor compares them.
module tb_pktc_mem_responder;

    localparam int AW    = 8;
    localparam int DW    = 64;
    localparam int CW    = 4;
    localparam int DEPTH = 256;
    localparam int CMAX  = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] f0_waddr = '0, f0_raddr = '0, f1_waddr = '0, f1_raddr = '0;
    logic [DW-1:0] f0_wdata = '0, f1_wdata = '0;
    logic          f0_write = 1'b0, f1_write = 1'b0, clr_stats = 1'b0;
    logic [DW-1:0] f0_rdata, f1_rdata;
    logic          init_done, wr_drop;
    logic [CW-1:0] f0_wr_cnt, f1_wr_cnt;

    pktc_mem_responder #(.DWIDTH(DW), .AWIDTH(AW), .CNTW(CW)) dut (
        .clk(clk), .rst(rst),
        .f0_waddr(f0_waddr), .f0_wdata(f0_wdata), .f0_write(f0_write),
        .f0_raddr(f0_raddr), .f0_rdata(f0_rdata),
        .f1_waddr(f1_waddr), .f1_wdata(f1_wdata), .f1_write(f1_write),
        .f1_raddr(f1_raddr), .f1_rdata(f1_rdata),
        .init_done(init_done), .f0_wr_cnt(f0_wr_cnt), .f1_wr_cnt(f1_wr_cnt),
        .wr_drop(wr_drop), .clr_stats(clr_stats)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [63:0] rd0;
        logic [63:0] rd1;
        int          cnt0;
        int          cnt1;
        bit          drop;
        bit          done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    // Reference model: memory reads as all-zero until the sweep has run for DEPTH cycles.
    logic [63:0] m0 [DEPTH];
    logic [63:0] m1 [DEPTH];
    int          since_reset = 0;
    int          cnt0 = 0, cnt1 = 0;
    bit          drop = 1'b0;

    task automatic checkOutput(input string name, input int cyc, input logic [63:0] got,
                               input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkOutput("f0_rdata",  mon_e.cyc, f0_rdata, mon_e.rd0);
            checkOutput("f1_rdata",  mon_e.cyc, f1_rdata, mon_e.rd1);
            checkOutput("f0_wr_cnt", mon_e.cyc, 64'(f0_wr_cnt), 64'(mon_e.cnt0));
            checkOutput("f1_wr_cnt", mon_e.cyc, 64'(f1_wr_cnt), 64'(mon_e.cnt1));
            checkOutput("wr_drop",   mon_e.cyc, 64'(wr_drop), 64'(mon_e.drop));
            checkOutput("init_done", mon_e.cyc, 64'(init_done), 64'(mon_e.done));
        end
    end

    task automatic applyStimulus(input bit r, input bit clr,
                                 input bit w0, input logic [7:0] wa0, input logic [63:0] wd0,
                                 input logic [7:0] ra0,
                                 input bit w1, input logic [7:0] wa1, input logic [63:0] wd1,
                                 input logic [7:0] ra1);
        exp_t e;
        bit   ready;
        @(posedge clk);
        #1;
        rst = r; clr_stats = clr;
        f0_write = w0; f0_waddr = wa0; f0_wdata = wd0; f0_raddr = ra0;
        f1_write = w1; f1_waddr = wa1; f1_wdata = wd1; f1_raddr = ra1;
        cyc_no++;

        ready  = !r && (since_reset >= DEPTH);
        e.cyc  = cyc_no;
        e.rd0  = ready ? m0[ra0] : 64'h0;
        e.rd1  = ready ? m1[ra1] : 64'h0;
        e.cnt0 = r ? 0 : cnt0;
        e.cnt1 = r ? 0 : cnt1;
        e.drop = r ? 1'b0 : drop;
        e.done = ready;
        exp_q.push_back(e);

        if (r) begin
            for (int i = 0; i < DEPTH; i++) begin
                m0[i] = 64'h0;
                m1[i] = 64'h0;
            end
            cnt0 = 0; cnt1 = 0; drop = 1'b0; since_reset = 0;
        end else begin
            if (clr) begin
                cnt0 = 0; cnt1 = 0; drop = 1'b0;
            end else begin
                if (w0 && ready) cnt0 = (cnt0 >= CMAX) ? CMAX : cnt0 + 1;
                if (w1 && ready) cnt1 = (cnt1 >= CMAX) ? CMAX : cnt1 + 1;
                if ((w0 || w1) && !ready) drop = 1'b1;
            end
            if (ready && w0) m0[wa0] = wd0;
            if (ready && w1) m1[wa1] = wd1;
            if (since_reset < DEPTH) since_reset++;
        end
    endtask

    task automatic runIdle(input int n, input bit r);
        for (int i = 0; i < n; i++)
            applyStimulus(r, 1'b0, 1'b0, 8'($urandom), 64'h0, 8'($urandom_range(0, 15)),
                          1'b0, 8'($urandom), 64'h0, 8'($urandom_range(0, 15)));
    endtask

    initial begin
        runIdle(3, 1'b1);
        // Sweep, with one write dropped at sweep cycle 10 to address 7.
        runIdle(10, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd7, 64'hCAFE_F00D_1234_5678, 8'd7,
                      1'b0, 8'd0, 64'h0, 8'd0);
        runIdle(250, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 64'h0, 8'd7, 1'b0, 8'd0, 64'h0, 8'd7);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 64'h0, 8'd7, 1'b0, 8'd0, 64'h0, 8'd7);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 64'h0, 8'd7, 1'b0, 8'd0, 64'h0, 8'd7);

        // Simultaneous writes to both banks, then read back.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd5, 64'hDEADBEEF_00000001, 8'd5,
                      1'b1, 8'd5, 64'h1234, 8'd5);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 64'h0, 8'd5, 1'b0, 8'd0, 64'h0, 8'd5);

        // Same-address read during write returns the old word.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd3, 64'hAA, 8'd0, 1'b0, 8'd0, 64'h0, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd3, 64'hBB, 8'd3, 1'b0, 8'd0, 64'h0, 8'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 64'h0, 8'd3, 1'b0, 8'd0, 64'h0, 8'd3);

        // Saturation: 20 writes, then clear together with a write.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 64'h0, 8'd0, 1'b0, 8'd0, 64'h0, 8'd0);
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom_range(0, 15)), {$urandom, $urandom},
                          8'($urandom_range(0, 15)), 1'b0, 8'd0, 64'h0, 8'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd9, 64'h99, 8'd9, 1'b1, 8'd9, 64'h77, 8'd9);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 64'h0, 8'd9, 1'b0, 8'd0, 64'h0, 8'd9);

        // Randomised traffic over a small address window so reads hit written words.
        for (int i = 0; i < 300; i++)
            applyStimulus(1'b0, ($urandom_range(0, 31) == 0),
                          1'($urandom), 8'($urandom_range(0, 15)), {$urandom, $urandom},
                          8'($urandom_range(0, 15)),
                          1'($urandom), 8'($urandom_range(0, 15)), {$urandom, $urandom},
                          8'($urandom_range(0, 15)));

        // Reset in the middle of a sweep restarts it from the beginning.
        runIdle(2, 1'b1);
        runIdle(100, 1'b0);
        runIdle(2, 1'b1);
        runIdle(260, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
